ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 162 ++++++++++++++++
 tb/tb_ifetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Generic single-clock FIFO with synchronous flush; flush wins over push/pop.
// Latency: a push is visible at rd_dat the cycle after it is written.
// Backpressure: full is exported; a push while full is dropped unless a pop frees space.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  assign rd_vld = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_dat = mem[rd_ptr];
  assign do_rd  = rd_vld & rd_rdy;
  assign do_wr  = wr_vld & (~full | do_rd);

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Instruction prefetcher: one outstanding imem request, results queued as {pc, instr}.
// Latency: request issues the edge after FETCH is entered; response visible at head one edge after rvalid.
// Backpressure: stops requesting while the queue is full; redirect flushes queue and drops any in-flight reply.
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, req_pc, redirect_tgt;
  logic        issue, push, fifo_full;
  fetch_ent_t  push_ent, head_ent;

  // Targets are word aligned; the low two bits of redirect_pc are discarded.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign push_ent     = {req_pc, imem_rdata};
  assign instr        = head_ent.instr;
  assign instr_pc     = head_ent.pc;

  // Next-state and request/push decisions; redirect suppresses both.
  always_comb begin
    issue     = 1'b0;
    push      = 1'b0;
    state_nxt = state;
    case (state)
      FETCH: begin
        if (!redirect && !fifo_full) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = ~redirect;
          state_nxt = FETCH;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // State, fetch pointer and registered request outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state    <= state_nxt;
      imem_req <= issue;
      if (issue) begin
        imem_addr <= fetch_pc;
        req_pc    <= fetch_pc;
      end
      if (redirect) fetch_pc <= redirect_tgt;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  sync_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (redirect),
    .wr_vld  (push),
    .wr_dat  (push_ent),
    .rd_rdy  (instr_ready),
    .rd_vld  (instr_valid),
    .rd_dat  (head_ent),
    .full    (fifo_full)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, full stall, redirects, wrap, async reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// A simple memory model (mem_on) answers every request in the cycle imem_req is seen.
module tb_ifetch_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mem_on = 1'b0;
  bit          found;
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  int          pop_cyc[$];

  ifetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; log pops seen at the edge, then model memory and log requests.
  task automatic tick();
    if (instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
      pop_cyc.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (mem_on) begin
      imem_rvalid = imem_req;
      imem_rdata  = imem_req ? word(imem_addr) : 32'h0;
    end
    if (imem_req) req_log.push_back(imem_addr);
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    mem_on      = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_req(input logic [31:0] addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (imem_req && imem_addr == addr) ok = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset_n is held low
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_logs();

    // Streaming: first request on the first edge after release, one instr per 2 cycles
    mem_on      = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 40 && pop_pc.size() < 4; i++) tick();
    chk("stream_pops", pop_pc.size(), 32'd4);
    for (int i = 0; i < pop_pc.size() && i < 4; i++) begin
      chk("stream_pc", pop_pc[i], 32'(i * 4));
      chk("stream_ins", pop_ins[i], word(32'(i * 4)));
      if (i > 0) chk("stream_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    end

    // Full stall: exactly four requests, then one pop re-opens fetching a cycle later
    do_reset();
    mem_on = 1'b1;
    repeat (20) tick();
    chk("stall_nreq", req_log.size(), 32'd4);
    for (int i = 0; i < req_log.size() && i < 4; i++) chk("stall_addr", req_log[i], 32'(i * 4));
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_head", instr_pc, 32'h0);
    chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_noreq", {31'd0, imem_req}, 32'd0);
    chk("pop_head", instr_pc, 32'h4);
    tick();
    chk("pop_req", {31'd0, imem_req}, 32'd1);
    chk("pop_addr", imem_addr, 32'd16);

    // Redirect while waiting on the request to 8
    do_reset();
    mem_on = 1'b1;
    wait_req(32'h8, 20, found);
    chk("rdw_found", {31'd0, found}, 32'd1);
    mem_on      = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("rdw_state", 32'(dut.state), 32'd2);
    chk("rdw_flush", {31'd0, instr_valid}, 32'd0);
    chk("rdw_noreq", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word(32'h8);
    tick();
    imem_rvalid = 1'b0;
    chk("rdw_drop", {31'd0, instr_valid}, 32'd0);
    chk("rdw_state2", 32'(dut.state), 32'd0);
    mem_on = 1'b1;
    tick();
    chk("rdw_req", {31'd0, imem_req}, 32'd1);
    chk("rdw_addr", imem_addr, 32'h40);
    tick();
    chk("rdw_valid", {31'd0, instr_valid}, 32'd1);
    chk("rdw_pc", instr_pc, 32'h40);
    chk("rdw_ins", instr, word(32'h40));

    // Redirect, rvalid and pop all in one cycle with two entries queued
    do_reset();
    mem_on = 1'b1;
    wait_req(32'h8, 20, found);
    chk("sim_found", {31'd0, found}, 32'd1);
    chk("sim_valid0", {31'd0, instr_valid}, 32'd1);
    mem_on      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    instr_ready = 1'b1;
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    chk("sim_empty", {31'd0, instr_valid}, 32'd0);
    chk("sim_state", 32'(dut.state), 32'd0);
    chk("sim_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("sim_req", {31'd0, imem_req}, 32'd1);
    chk("sim_addr", imem_addr, 32'h100);

    // Misaligned redirect target and address wrap
    do_reset();
    mem_on      = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wrap_noreq", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 10 && req_log.size() < 2; i++) tick();
    chk("wrap_nreq", req_log.size(), 32'd2);
    if (req_log.size() >= 2) begin
      chk("wrap_a0", req_log[0], 32'hFFFF_FFFC);
      chk("wrap_a1", req_log[1], 32'h0000_0000);
    end
    chk("wrap_npop", pop_pc.size(), 32'd1);
    if (pop_pc.size() >= 1) chk("wrap_pop", pop_pc[0], 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of an outstanding request
    do_reset();
    mem_on = 1'b1;
    wait_req(32'h8, 20, found);
    chk("ar_found", {31'd0, found}, 32'd1);
    mem_on      = 1'b0;
    imem_rvalid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_state", 32'(dut.state), 32'd0);
    @(negedge clock);
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = word(32'h8);
    tick();
    imem_rvalid = 1'b0;
    chk("ar_first_req", {31'd0, imem_req}, 32'd1);
    chk("ar_first_addr", imem_addr, 32'h0);
    chk("ar_late_ign", {31'd0, instr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
